// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: run-state encoding and instruction-cycle length shared with the clock generator
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {HALTED = 2'd0, RUN = 2'd1, STEP = 2'd2} run_state_t;
  localparam int PHASES = 3;
endpackage

// File: rtl/run_control_if.sv
// run_control_if: front-panel buttons, CPU halt pulse and clock-generator control outputs
interface run_control_if;
  logic btn_run;
  logic btn_step;
  logic btn_halt;
  logic hlt_instr;
  logic halt;
  logic reset;
  logic running;
  logic stepping;
  modport master (output btn_run, btn_step, btn_halt, hlt_instr, input halt, reset, running, stepping);
  modport slave (input btn_run, btn_step, btn_halt, hlt_instr, output halt, reset, running, stepping);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, stability counter and one-cycle press strobe
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, lvl, flip;
  logic [CW-1:0] cnt;
  // the sample that would make the count reach DEBOUNCE_CYCLES flips the level directly
  assign flip = (s2 != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl   <= flip ? s2 : lvl;
      cnt   <= (s2 == lvl || flip) ? '0 : cnt + CW'(1);
      press <= flip & s2;
    end
endmodule

// File: rtl/run_control.sv
// run_control: button-driven HALTED/RUN/STEP sequencer with stretched reset for the clock generator
module run_control
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_HOLD      = 4,
  parameter int PHASES          = cpu_ctrl_pkg::PHASES
) (
  input logic         clk,
  input logic         reset_n,
  run_control_if.slave bus
);
  localparam int RW = $clog2(RESET_HOLD + 1);
  localparam int PW = $clog2(PHASES + 1);
  localparam logic [1:0] ST_HALTED = HALTED;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_STEP   = STEP;
  logic run_p, step_p, halt_p, reset_q, last;
  logic [RW-1:0] rcnt;
  logic [PW-1:0] ph;
  logic [1:0] state, nxt;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run  (.clk(clk), .reset_n(reset_n), .btn(bus.btn_run),  .press(run_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (.clk(clk), .reset_n(reset_n), .btn(bus.btn_step), .press(step_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (.clk(clk), .reset_n(reset_n), .btn(bus.btn_halt), .press(halt_p));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      reset_q <= 1'b1;
      rcnt    <= '0;
    end else if (reset_q) begin
      reset_q <= rcnt != RW'(RESET_HOLD - 1);
      rcnt    <= rcnt + RW'(1);
    end
  // a step always runs its full cycle: strobes and hlt_instr are ignored in STEP
  always_comb begin
    last = ph == PW'(PHASES - 1);
    nxt  = state == ST_HALTED ? (halt_p ? ST_HALTED : step_p ? ST_STEP : run_p ? ST_RUN : ST_HALTED) :
           state == ST_RUN    ? ((halt_p || bus.hlt_instr) ? ST_HALTED : ST_RUN) :
           state == ST_STEP   ? (last ? ST_HALTED : ST_STEP) : ST_HALTED;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_HALTED;
      ph    <= '0;
    end else if (reset_q) begin
      state <= ST_HALTED;
      ph    <= '0;
    end else begin
      state <= nxt;
      ph    <= (state == ST_STEP && !last) ? ph + PW'(1) : '0;
    end
  assign bus.halt     = state == ST_HALTED;
  assign bus.running  = state == ST_RUN;
  assign bus.stepping = state == ST_STEP;
  assign bus.reset    = reset_q;
endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed button scenarios checked against a timestamp-based behavioural model
module tb_run_control;
  localparam int D = 16;
  localparam int H = 4;
  localparam int P = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  run_control_if bus();
  run_control #(.DEBOUNCE_CYCLES(D), .RESET_HOLD(H), .PHASES(P)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: a button level is accepted once its delayed samples have differed for D edges
  // since the last matching sample (tracked as an edge timestamp); mode 0/1/2 = halted/run/step
  int n, mode, left;
  int mark[3];
  logic mreset, seen;
  logic raw[3], mr1[3], mr2[3], mlvl[3], mpress[3];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      n = 0; mode = 0; left = 0; mreset = 1'b1;
      for (int b = 0; b < 3; b++) begin
        mark[b] = 0; mr1[b] = 1'b0; mr2[b] = 1'b0; mlvl[b] = 1'b0; mpress[b] = 1'b0;
      end
    end else begin
      raw[0] = bus.btn_run; raw[1] = bus.btn_step; raw[2] = bus.btn_halt;
      n++;
      if (mreset) mode = 0;
      else if (mode == 0) begin
        if (mpress[2]) mode = 0;
        else if (mpress[1]) begin mode = 2; left = P; end
        else if (mpress[0]) mode = 1;
      end else if (mode == 1) begin
        if (mpress[2] || bus.hlt_instr) mode = 0;
      end else begin
        left--;
        if (left == 0) mode = 0;
      end
      mreset = n < H;
      for (int b = 0; b < 3; b++) begin
        seen = mr2[b]; mr2[b] = mr1[b]; mr1[b] = raw[b]; mpress[b] = 1'b0;
        if (seen == mlvl[b]) mark[b] = n;
        else if (n - mark[b] == D) begin
          mlvl[b] = seen; mark[b] = n; mpress[b] = seen;
        end
      end
    end

  always @(negedge clk) begin
    chk("m_halt", bus.halt, mode == 0);
    chk("m_running", bus.running, mode == 1);
    chk("m_stepping", bus.stepping, mode == 2);
    chk("m_reset", bus.reset, mreset);
  end

  task automatic ticks(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    bus.btn_run = 0; bus.btn_step = 0; bus.btn_halt = 0; bus.hlt_instr = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_reset", bus.reset, 1); chk("rst_halt", bus.halt, 1);
    chk("rst_running", bus.running, 0); chk("rst_stepping", bus.stepping, 0);
    ticks(3); reset_n = 1;
    ticks(3); chk("rst_hold3", bus.reset, 1);
    ticks(1); chk("rst_rel4", bus.reset, 0); chk("rst_rel_halt", bus.halt, 1);
    // clean run, then clean halt
    ticks(2); bus.btn_run = 1;
    ticks(18); chk("run_e18", bus.halt, 1);
    ticks(1); chk("run_e19_halt", bus.halt, 0); chk("run_e19_running", bus.running, 1);
    bus.btn_run = 0; ticks(25); chk("run_hold", bus.running, 1);
    bus.btn_halt = 1;
    ticks(18); chk("hbtn_e18", bus.halt, 0);
    ticks(1); chk("hbtn_e19", bus.halt, 1); chk("hbtn_running", bus.running, 0);
    bus.btn_halt = 0; ticks(25);
    // bounce shorter than the debounce window
    for (int i = 0; i < 12; i++) begin bus.btn_run = ~bus.btn_run; ticks(5); end
    ticks(30); chk("bounce_halt", bus.halt, 1); chk("bounce_running", bus.running, 0);
    // single step, with a run strobe and hlt_instr landing mid-step
    bus.btn_step = 1; ticks(1); bus.btn_run = 1;
    ticks(17); chk("step_e18", bus.halt, 1);
    ticks(1); chk("step_e19_st", bus.stepping, 1); chk("step_e19_halt", bus.halt, 0);
    ticks(1); chk("step_e20", bus.stepping, 1);
    bus.hlt_instr = 1; ticks(1); bus.hlt_instr = 0;
    chk("step_e21_st", bus.stepping, 1); chk("step_e21_halt", bus.halt, 0);
    ticks(1); chk("step_e22_halt", bus.halt, 1); chk("step_e22_st", bus.stepping, 0);
    ticks(3); chk("step_after_run", bus.running, 0);
    bus.btn_step = 0; bus.btn_run = 0; ticks(25);
    // hlt_instr in RUN
    bus.btn_run = 1; ticks(19); chk("hlt_pre_run", bus.running, 1);
    bus.btn_run = 0; ticks(5);
    bus.hlt_instr = 1; ticks(1); bus.hlt_instr = 0;
    chk("hlt_halt", bus.halt, 1); chk("hlt_running", bus.running, 0);
    ticks(25);
    // simultaneous strobes
    bus.btn_run = 1; bus.btn_halt = 1; ticks(19);
    chk("pri_rh_halt", bus.halt, 1); chk("pri_rh_running", bus.running, 0);
    bus.btn_run = 0; bus.btn_halt = 0; ticks(25);
    bus.btn_run = 1; bus.btn_step = 1; ticks(19);
    chk("pri_rs_step", bus.stepping, 1);
    ticks(3); chk("pri_rs_done", bus.halt, 1);
    bus.btn_run = 0; bus.btn_step = 0; ticks(25);
    bus.btn_halt = 1; bus.btn_step = 1; ticks(19);
    chk("pri_hs_halt", bus.halt, 1); chk("pri_hs_step", bus.stepping, 0);
    bus.btn_halt = 0; bus.btn_step = 0; ticks(25);
    // reset on the second step cycle
    bus.btn_step = 1; ticks(20); chk("mid_step", bus.stepping, 1);
    #2 reset_n = 0; bus.btn_step = 0;
    #1;
    chk("mid_rst_halt", bus.halt, 1); chk("mid_rst_st", bus.stepping, 0);
    chk("mid_rst_reset", bus.reset, 1); chk("mid_rst_running", bus.running, 0);
    ticks(2); reset_n = 1;
    ticks(10);
    chk("post_rst_halt", bus.halt, 1); chk("post_rst_st", bus.stepping, 0);
    chk("post_rst_reset", bus.reset, 0); chk("post_rst_running", bus.running, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_control.md
# run_control

Front-panel run/stop controller that sits directly upstream of the three-phase clock generator and drives its `halt` and `reset` inputs. It conditions raw run, step and halt buttons with synchronisation and debouncing, and stretches the board reset. It sequences a HALTED / RUN / STEP state machine, so the processor can free-run, stop on command or on a HLT instruction, or advance exactly one instruction cycle (three phases).

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable clk samples required before a button level is accepted; minimum 2.
- `RESET_HOLD`, default 4: clk cycles `reset` stays high after `reset_n` deasserts; minimum 1.
- `PHASES`, default 3: clk cycles per instruction cycle, equal to the clock generator's phase count.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `btn_run`  in  1  raw run button, asynchronous to clk, active-high.
- `btn_step`  in  1  raw single-step button, asynchronous to clk, active-high.
- `btn_halt`  in  1  raw halt button, asynchronous to clk, active-high.
- `hlt_instr`  in  1  one-clk pulse from the CPU when a HLT instruction executes; synchronous to clk.
- `halt`  out  1  drives the clock generator's `halt` input.
- `reset`  out  1  synchronous, stretched active-high reset; drives the clock generator and the CPU.
- `running`  out  1  high while in RUN.
- `stepping`  out  1  high while in STEP.

## Operation
- Reset values: asserting `reset_n` low sets the following immediately (asynchronously):
  - `reset`=1, `halt`=1, `running`=0, `stepping`=0
  - state=HALTED
  - debounced button levels=0
  - every counter=0
- Reset stretch:
  - after `reset_n` rises, `reset` stays 1 for exactly RESET_HOLD rising edges, then goes to 0.
  - the FSM is forced to HALTED while `reset`=1, and button strobes are discarded during that time.
- Button path, per button:
  - 2-flop synchroniser, then the debouncer.
  - the debouncer counts consecutive samples where the synchronised level differs from the accepted level.
  - any sample that matches the accepted level clears the count.
  - when the count reaches DEBOUNCE_CYCLES, the accepted level flips and the count clears.
  - a 0→1 flip produces a one-cycle press strobe on the same edge; release produces no strobe.
- FSM transitions:
  - HALTED: `halt_press` → stay HALTED; else `step_press` → STEP; else `run_press` → RUN. Priority is halt > step > run.
  - RUN: `halt_press` or `hlt_instr` → HALTED; `run_press` and `step_press` are ignored.
  - STEP: a phase counter counts 0..PHASES-1; on count PHASES-1 the FSM goes to HALTED.
  - STEP: all press strobes are ignored. `hlt_instr` is also ignored, so the step always completes its full cycle.
- Outputs decoded from registered state:
  - `halt` = (state==HALTED); `running` = (state==RUN); `stepping` = (state==STEP).
  - all outputs are registered, with no combinational path from any input.

## Timing
- Button latency: a raw button rise that stays clean changes `halt` on the (DEBOUNCE_CYCLES+3)th rising edge after the raw rise. This is 2 synchroniser edges, DEBOUNCE_CYCLES edges to the strobe, and 1 FSM edge; 19 edges at the default.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES consecutive samples produces no strobe.
- `hlt_instr` in RUN: `halt`=1 on the next rising edge.
- STEP: `halt` is 0 for exactly PHASES consecutive clk cycles, then returns to 1. Because the clock generator keeps its phase position across halt, each step emits exactly one cycle, ram and internal strobe.
- Reset mid-operation: `reset_n` low at any point, including mid-STEP or mid-debounce, returns all outputs to their reset values without waiting for a clock edge.
- Simultaneous strobes on the same edge follow the HALTED priority above.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - `run_state_t` enum {HALTED, RUN, STEP}.
  - `PHASES` constant, also used by the clock generator so both agree on cycle length.
- Sub-module `button_debounce`, instantiated three times:
  - contains the synchroniser, counter and accepted level, and produces the press strobe.
  - counter width is $clog2(DEBOUNCE_CYCLES+1).
- Top level holds the reset-stretch counter, the FSM and the phase counter.

## Test plan
- Reset: hold `reset_n` low 3 cycles → `reset`=1 and `halt`=1 immediately. Release → `reset` falls on the 4th edge, `halt` stays 1, and state is HALTED.
- Clean run: `btn_run` held high from cycle 10 → `halt`=0 and `running`=1 at edge 29. A later clean `btn_halt` press → `halt`=1 exactly 19 edges after its raw rise.
- Bounce: `btn_run` toggled every 5 cycles for 60 cycles, then held low → no strobe, and `halt` remains 1.
- Single step: `btn_step` press in HALTED → `stepping`=1 and `halt`=0 for exactly 3 cycles, then `halt`=1. A second step press arriving mid-STEP is ignored.
- HLT instruction and priority:
  - in RUN, a one-cycle `hlt_instr` pulse → `halt`=1 on the next edge.
  - `btn_run` and `btn_halt` debounced to the same edge while HALTED → state remains HALTED.
- Reset mid-step: `reset_n` pulled low on the 2nd STEP cycle → `halt`=1, `stepping`=0, `reset`=1 asynchronously. After release, the FSM stays HALTED.
